// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron decay scheduler: float/rate widths,
// default address width and the scheduler state encoding.
package neuron_pkg;

   localparam int FLOAT_WIDTH        = 32;
   localparam int RATE_WIDTH         = 5;
   localparam int DEFAULT_ADDR_WIDTH = 12;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } sched_state_t;

endpackage

// File: rtl/neuron_address_counter.sv
// Neuron address counter for the decay sweep: load-zero, saturating
// increment and a flag marking the last neuron of the cluster.
module neuron_address_counter
   import neuron_pkg::*;
#(
   parameter int NEURON_COUNT = 1024,
   parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  load_zero,
   input  logic                  incr,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  is_last
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NEURON_COUNT - 1);

   logic [ADDR_WIDTH-1:0] addr_reg;

   // Never steps past the last neuron, so a sweep cannot wrap.
   always_ff @(posedge clk) begin
      if (srst || load_zero) begin
         addr_reg <= '0;
      end else if (incr && !is_last) begin
         addr_reg <= addr_reg + 1'b1;
      end
   end

   assign addr    = addr_reg;
   assign is_last = (addr_reg == LAST_ADDR);

endmodule

// File: rtl/potential_decay_scheduler.sv
// Sweeps all neurons through the shared decay unit on each timestep pulse.
// Optional DECAY_SKIP_ZERO_EN: neurons holding +/-0.0 skip decay and writeback.
module potential_decay_scheduler
   import neuron_pkg::*;
#(
   parameter int NEURON_COUNT = 1024,
   parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   timestep_start,
   output logic                   mem_rd_en,
   output logic [ADDR_WIDTH-1:0]  mem_rd_addr,
   input  logic [FLOAT_WIDTH-1:0] mem_rd_data,
   input  logic [RATE_WIDTH-1:0]  mem_rd_rate,
   output logic                   mem_wr_en,
   output logic [ADDR_WIDTH-1:0]  mem_wr_addr,
   output logic [FLOAT_WIDTH-1:0] mem_wr_data,
   output logic                   dec_start,
   output logic [FLOAT_WIDTH-1:0] dec_potential,
   output logic [RATE_WIDTH-1:0]  dec_rate,
   input  logic                   dec_done,
   input  logic [FLOAT_WIDTH-1:0] dec_result,
   input  logic                   acc_req,
   output logic                   acc_grant,
   output logic                   busy,
   output logic                   sweep_done,
   output logic                   overrun
);

   sched_state_t           state_reg;
   logic                   rd_en_reg;
   logic                   issue_reg;
   logic                   wr_en_reg;
   logic                   done_reg;
   logic                   busy_reg;
   logic                   overrun_reg;
   logic [FLOAT_WIDTH-1:0] result_reg;

   logic [ADDR_WIDTH-1:0]  addr;
   logic                   is_last;
   logic                   skip_zero;
   logic                   load_zero;
   logic                   incr;

`ifdef DECAY_SKIP_ZERO_EN
   assign skip_zero = (mem_rd_data[FLOAT_WIDTH-2:0] == '0);
`else
   assign skip_zero = 1'b0;
`endif

   assign load_zero = (state_reg == ST_IDLE) && timestep_start;
   assign incr      = ((state_reg == ST_WRITE) ||
                       ((state_reg == ST_ISSUE) && skip_zero)) && !is_last;

   neuron_address_counter #(
      .NEURON_COUNT (NEURON_COUNT),
      .ADDR_WIDTH   (ADDR_WIDTH)
   ) u_addr (
      .clk       (CLK),
      .srst      (RESET),
      .load_zero (load_zero),
      .incr      (incr),
      .addr      (addr),
      .is_last   (is_last)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg   <= ST_IDLE;
         rd_en_reg   <= 1'b0;
         issue_reg   <= 1'b0;
         wr_en_reg   <= 1'b0;
         done_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         overrun_reg <= 1'b0;
         result_reg  <= '0;
      end else begin
         rd_en_reg <= 1'b0;
         issue_reg <= 1'b0;
         wr_en_reg <= 1'b0;
         done_reg  <= 1'b0;
         if (timestep_start && busy_reg) begin
            overrun_reg <= 1'b1;
         end
         case (state_reg)
            ST_IDLE: begin
               if (timestep_start) begin
                  state_reg <= ST_READ;
                  rd_en_reg <= 1'b1;
                  busy_reg  <= 1'b1;
               end
            end
            ST_READ: begin
               state_reg <= ST_ISSUE;
               issue_reg <= 1'b1;
            end
            ST_ISSUE: begin
               // Zero potentials jump straight to the next-address decision.
               if (skip_zero) begin
                  if (is_last) begin
                     state_reg <= ST_DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg <= ST_READ;
                     rd_en_reg <= 1'b1;
                  end
               end else begin
                  state_reg <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (dec_done) begin
                  result_reg <= dec_result;
                  state_reg  <= ST_WRITE;
                  wr_en_reg  <= 1'b1;
               end
            end
            ST_WRITE: begin
               if (is_last) begin
                  state_reg <= ST_DONE;
                  done_reg  <= 1'b1;
               end else begin
                  state_reg <= ST_READ;
                  rd_en_reg <= 1'b1;
               end
            end
            ST_DONE: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
            end
            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign mem_rd_en     = rd_en_reg;
   assign mem_rd_addr   = rd_en_reg ? addr : '0;
   assign dec_start     = issue_reg && !skip_zero;
   assign dec_potential = dec_start ? mem_rd_data : '0;
   assign dec_rate      = dec_start ? mem_rd_rate : '0;
   // A reset arriving in the write cycle must not commit the write.
   assign mem_wr_en     = wr_en_reg && !RESET;
   assign mem_wr_addr   = mem_wr_en ? addr : '0;
   assign mem_wr_data   = mem_wr_en ? result_reg : '0;
   assign sweep_done    = done_reg;
   assign busy          = busy_reg;
   assign overrun       = overrun_reg;
   assign acc_grant     = (state_reg == ST_IDLE) && acc_req && !timestep_start && !RESET;

endmodule

// File: tb/tb_potential_decay_scheduler.sv
// Directed bench for potential_decay_scheduler with NEURON_COUNT=4, a memory
// model and a decay model that halves its operand after a programmable latency.
module tb_potential_decay_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        timestep_start;
   logic        mem_rd_en;
   logic [11:0] mem_rd_addr;
   logic [31:0] mem_rd_data;
   logic [4:0]  mem_rd_rate;
   logic        mem_wr_en;
   logic [11:0] mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic        dec_start;
   logic [31:0] dec_potential;
   logic [4:0]  dec_rate;
   logic        dec_done;
   logic [31:0] dec_result;
   logic        acc_req;
   logic        acc_grant;
   logic        busy;
   logic        sweep_done;
   logic        overrun;

   potential_decay_scheduler #(.NEURON_COUNT(4), .ADDR_WIDTH(12)) dut (
      .CLK(clk), .RESET(rst), .timestep_start(timestep_start),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data), .mem_rd_rate(mem_rd_rate),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .dec_start(dec_start), .dec_potential(dec_potential), .dec_rate(dec_rate),
      .dec_done(dec_done), .dec_result(dec_result),
      .acc_req(acc_req), .acc_grant(acc_grant),
      .busy(busy), .sweep_done(sweep_done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Membrane memory: registered read, data valid the cycle after the strobe.
   logic [31:0] mem [4];
   logic [4:0]  rate_mem [4];
   always @(posedge clk) begin
      if (mem_rd_en) begin
         mem_rd_data <= mem[mem_rd_addr[1:0]];
         mem_rd_rate <= rate_mem[mem_rd_addr[1:0]];
      end
      if (mem_wr_en) mem[mem_wr_addr[1:0]] <= mem_wr_data;
   end

   // Decay unit: result = operand / 2 (exponent - 1), dec_done dec_lat cycles after dec_start.
   int          dec_lat = 1;
   int          dcnt = 0;
   logic [31:0] dval = '0;
   always @(posedge clk) begin
      if (dec_start) begin
         dcnt <= dec_lat;
         dval <= {dec_potential[31], dec_potential[30:23] - 8'd1, dec_potential[22:0]};
      end else if (dcnt > 0) begin
         dcnt <= dcnt - 1;
      end
   end
   assign dec_done   = (dcnt == 1);
   assign dec_result = dec_done ? dval : 32'h0;

   int n_cmp = 0;
   int n_bad = 0;

   int          rd_n, ds_n, wr_n, done_cyc;
   int          rd_cyc [8];
   int          rd_adr [8];
   int          ds_cyc [8];
   logic [31:0] ds_pot [8];
   logic [4:0]  ds_rate [8];
   int          wr_cyc [8];
   int          wr_adr [8];
   logic [31:0] wr_dat [8];
   logic        grant_at [64];
   logic        ovr_at [64];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulses start at k=0 (and again at extra_k), recording every strobe by cycle offset.
   task automatic run_sweep(input int max_k, input int extra_k);
      rd_n = 0; ds_n = 0; wr_n = 0; done_cyc = -1;
      for (int k = 0; k <= max_k; k++) begin
         timestep_start = (k == 0) || (k == extra_k);
         #1;
         grant_at[k] = acc_grant;
         ovr_at[k]   = overrun;
         if (mem_rd_en) begin
            if (rd_n < 8) begin rd_cyc[rd_n] = k; rd_adr[rd_n] = int'(mem_rd_addr); end
            rd_n++;
         end
         if (dec_start) begin
            if (ds_n < 8) begin ds_cyc[ds_n] = k; ds_pot[ds_n] = dec_potential; ds_rate[ds_n] = dec_rate; end
            ds_n++;
         end
         if (mem_wr_en) begin
            if (wr_n < 8) begin wr_cyc[wr_n] = k; wr_adr[wr_n] = int'(mem_wr_addr); wr_dat[wr_n] = mem_wr_data; end
            wr_n++;
         end
         if (sweep_done && done_cyc < 0) done_cyc = k;
         tick();
      end
      timestep_start = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; timestep_start = 1'b0; acc_req = 1'b0;
      repeat (3) tick();
      n_cmp++; if ({mem_rd_en, mem_wr_en, dec_start, sweep_done} !== 4'b0) begin n_bad++; $display("FAIL reset_strobes: got %b expected 0000", {mem_rd_en, mem_wr_en, dec_start, sweep_done}); end
      n_cmp++; if ({busy, overrun, acc_grant} !== 3'b0) begin n_bad++; $display("FAIL reset_status: got %b expected 000", {busy, overrun, acc_grant}); end
      n_cmp++; if ({mem_rd_addr, mem_wr_addr, mem_wr_data} !== 56'h0) begin n_bad++; $display("FAIL reset_buses: got %h expected 0", {mem_rd_addr, mem_wr_addr, mem_wr_data}); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_sweep();
      logic [31:0] exp_half [4];
      int          gr1;
      exp_half[0] = 32'h40800000; exp_half[1] = 32'h3F000000;
      exp_half[2] = 32'hBF800000; exp_half[3] = 32'h41800000;
      mem[0] <= 32'h41000000; mem[1] <= 32'h3F800000; mem[2] <= 32'hC0000000; mem[3] <= 32'h42000000;
      rate_mem[0] <= 5'd3; rate_mem[1] <= 5'd7; rate_mem[2] <= 5'd12; rate_mem[3] <= 5'd31;
      dec_lat = 1;
      acc_req = 1'b1;
      tick();
      n_cmp++; if (acc_grant !== 1'b1) begin n_bad++; $display("FAIL grant_idle: got %b expected 1", acc_grant); end
      run_sweep(20, -1);
      n_cmp++; if (rd_n !== 4 || ds_n !== 4 || wr_n !== 4) begin n_bad++; $display("FAIL basic_counts: got rd=%0d ds=%0d wr=%0d expected 4/4/4", rd_n, ds_n, wr_n); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (rd_cyc[i] !== 1 + 4*i || rd_adr[i] !== i) begin n_bad++; $display("FAIL basic_read%0d: got cyc=%0d addr=%0d expected cyc=%0d addr=%0d", i, rd_cyc[i], rd_adr[i], 1 + 4*i, i); end
         n_cmp++; if (ds_cyc[i] !== 2 + 4*i || ds_rate[i] !== rate_mem[i]) begin n_bad++; $display("FAIL basic_issue%0d: got cyc=%0d rate=%0d expected cyc=%0d rate=%0d", i, ds_cyc[i], ds_rate[i], 2 + 4*i, rate_mem[i]); end
         n_cmp++; if (wr_cyc[i] !== 4 + 4*i || wr_adr[i] !== i || wr_dat[i] !== exp_half[i]) begin n_bad++; $display("FAIL basic_write%0d: got cyc=%0d addr=%0d data=%h expected cyc=%0d addr=%0d data=%h", i, wr_cyc[i], wr_adr[i], wr_dat[i], 4 + 4*i, i, exp_half[i]); end
      end
      n_cmp++; if (ds_pot[0] !== 32'h41000000) begin n_bad++; $display("FAIL basic_operand: got %h expected 41000000", ds_pot[0]); end
      n_cmp++; if (done_cyc !== 17) begin n_bad++; $display("FAIL basic_sweep_done: got %0d expected 17", done_cyc); end
      n_cmp++; if (mem[0] !== 32'h40800000) begin n_bad++; $display("FAIL basic_mem0: got %h expected 40800000", mem[0]); end
      gr1 = 0;
      for (int k = 0; k <= 17; k++) if (grant_at[k] !== 1'b0) gr1++;
      n_cmp++; if (gr1 !== 0) begin n_bad++; $display("FAIL grant_during_sweep: got %0d granted cycles expected 0", gr1); end
      n_cmp++; if (grant_at[18] !== 1'b1) begin n_bad++; $display("FAIL grant_after_done: got %b expected 1", grant_at[18]); end
      n_cmp++; if (ovr_at[20] !== 1'b0) begin n_bad++; $display("FAIL basic_no_overrun: got %b expected 0", ovr_at[20]); end
      acc_req = 1'b0;
   endtask

   task automatic test_latency5();
      dec_lat = 5;
      run_sweep(40, -1);
      n_cmp++; if (ds_n !== 4 || wr_n !== 4) begin n_bad++; $display("FAIL lat5_counts: got ds=%0d wr=%0d expected 4/4", ds_n, wr_n); end
      n_cmp++; if (wr_cyc[0] - ds_cyc[0] !== 6) begin n_bad++; $display("FAIL lat5_spacing: got %0d expected 6", wr_cyc[0] - ds_cyc[0]); end
      n_cmp++; if (ds_cyc[1] !== 10 || wr_cyc[3] !== 32) begin n_bad++; $display("FAIL lat5_timing: got ds1=%0d wr3=%0d expected 10/32", ds_cyc[1], wr_cyc[3]); end
      n_cmp++; if (done_cyc !== 33) begin n_bad++; $display("FAIL lat5_sweep_done: got %0d expected 33", done_cyc); end
      dec_lat = 1;
   endtask

   task automatic test_overrun();
      run_sweep(20, 6);
      n_cmp++; if (ovr_at[6] !== 1'b0) begin n_bad++; $display("FAIL overrun_before: got %b expected 0", ovr_at[6]); end
      n_cmp++; if (ovr_at[7] !== 1'b1 || ovr_at[20] !== 1'b1) begin n_bad++; $display("FAIL overrun_sticky: got %b%b expected 11", ovr_at[7], ovr_at[20]); end
      n_cmp++; if (wr_n !== 4 || rd_n !== 4) begin n_bad++; $display("FAIL overrun_writes: got wr=%0d rd=%0d expected 4/4", wr_n, rd_n); end
      n_cmp++; if (rd_adr[1] !== 1 || done_cyc !== 17) begin n_bad++; $display("FAIL overrun_continue: got addr1=%0d done=%0d expected 1/17", rd_adr[1], done_cyc); end
   endtask

   task automatic test_reset_mid_sweep();
      int stray;
      do_reset();
      dec_lat = 5;
      timestep_start = 1'b1;
      tick();
      timestep_start = 1'b0;
      repeat (11) tick();
      rst = 1'b1;
      #1;
      n_cmp++; if (mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_cycle_write: got %b expected 0", mem_wr_en); end
      tick();
      rst = 1'b0;
      n_cmp++; if (busy !== 1'b0 || mem_wr_en !== 1'b0 || dec_start !== 1'b0) begin n_bad++; $display("FAIL rst_mid_state: got busy=%b wr=%b ds=%b expected 000", busy, mem_wr_en, dec_start); end
      stray = 0;
      for (int k = 0; k < 10; k++) begin
         if (mem_wr_en || mem_rd_en || busy) stray++;
         tick();
      end
      n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL rst_abandoned: got %0d active cycles expected 0", stray); end
      dec_lat = 1;
      run_sweep(20, -1);
      n_cmp++; if (rd_cyc[0] !== 1 || rd_adr[0] !== 0 || wr_n !== 4 || done_cyc !== 17) begin n_bad++; $display("FAIL rst_restart: got rd@%0d addr=%0d wr=%0d done=%0d expected 1/0/4/17", rd_cyc[0], rd_adr[0], wr_n, done_cyc); end
      n_cmp++; if (ovr_at[20] !== 1'b0) begin n_bad++; $display("FAIL rst_overrun_clear: got %b expected 0", ovr_at[20]); end
   endtask

   task automatic test_start_vs_acc();
      acc_req = 1'b1;
      timestep_start = 1'b1;
      #1;
      n_cmp++; if (acc_grant !== 1'b0) begin n_bad++; $display("FAIL grant_start_priority: got %b expected 0", acc_grant); end
      tick();
      timestep_start = 1'b0;
      n_cmp++; if (busy !== 1'b1 || mem_rd_en !== 1'b1 || acc_grant !== 1'b0) begin n_bad++; $display("FAIL start_taken: got busy=%b rd=%b grant=%b expected 110", busy, mem_rd_en, acc_grant); end
      repeat (20) tick();
      acc_req = 1'b0;
   endtask

`ifdef DECAY_SKIP_ZERO_EN
   task automatic test_skip_zero();
      mem[0] <= 32'h00000000; mem[1] <= 32'h80000000; mem[2] <= 32'h3F800000; mem[3] <= 32'h00000000;
      tick();
      run_sweep(16, -1);
      n_cmp++; if (ds_n !== 1 || wr_n !== 1 || rd_n !== 4) begin n_bad++; $display("FAIL skip_counts: got ds=%0d wr=%0d rd=%0d expected 1/1/4", ds_n, wr_n, rd_n); end
      n_cmp++; if (ds_cyc[0] !== 6 || ds_pot[0] !== 32'h3F800000) begin n_bad++; $display("FAIL skip_issue: got cyc=%0d pot=%h expected 6/3f800000", ds_cyc[0], ds_pot[0]); end
      n_cmp++; if (wr_adr[0] !== 2 || wr_dat[0] !== 32'h3F000000) begin n_bad++; $display("FAIL skip_write: got addr=%0d data=%h expected 2/3f000000", wr_adr[0], wr_dat[0]); end
      n_cmp++; if (done_cyc !== 11) begin n_bad++; $display("FAIL skip_sweep_done: got %0d expected 11", done_cyc); end
   endtask
`endif

   initial begin
      rst = 1'b1; timestep_start = 1'b0; acc_req = 1'b0;
      test_reset();
      test_basic_sweep();
      test_latency5();
      test_overrun();
      test_reset_mid_sweep();
      test_start_vs_acc();
`ifdef DECAY_SKIP_ZERO_EN
      test_skip_zero();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/potential_decay_scheduler.md
# potential_decay_scheduler

Timestep-driven controller that sequences the shared `potential_decay` datapath across every neuron in a cluster. On each timestep pulse it walks neuron addresses 0..NEURON_COUNT-1 and, for each neuron:
- reads the membrane potential and decay rate from the membrane memory;
- issues them to the decay unit;
- waits for the result and writes it back to memory.

While idle it grants the membrane memory port to the spike accumulator.

## Interface
- NEURON_COUNT, 1024, neurons per sweep (2..4096)
- ADDR_WIDTH, 12, neuron address width
- CLK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-high reset
- timestep_start  in  1  one-cycle pulse that starts a sweep
- mem_rd_en  out  1  membrane memory read strobe
- mem_rd_addr  out  ADDR_WIDTH  read address
- mem_rd_data  in  32  IEEE-754 potential, valid the cycle after mem_rd_en
- mem_rd_rate  in  5  decay rate code, valid with mem_rd_data
- mem_wr_en  out  1  write strobe
- mem_wr_addr  out  ADDR_WIDTH  write address
- mem_wr_data  out  32  decayed potential
- dec_start  out  1  one-cycle request to the decay unit
- dec_potential  out  32  operand, valid with dec_start
- dec_rate  out  5  rate code, valid with dec_start
- dec_done  in  1  decay result valid (≥1 cycle after dec_start)
- dec_result  in  32  decayed value, valid with dec_done
- acc_req  in  1  accumulator requests the memory port
- acc_grant  out  1  port granted to the accumulator this cycle
- busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse at the end of a sweep
- overrun  out  1  sticky: timestep_start arrived while busy

## Operation
- States: IDLE, READ, ISSUE, WAIT, WRITE, DONE.
- IDLE:
  - timestep_start=1 → READ, with addr=0.
  - Otherwise acc_grant = acc_req.
  - timestep_start has priority over acc_req: no grant in the start cycle.
- READ: mem_rd_en=1, mem_rd_addr=addr → ISSUE.
- ISSUE: dec_start=1, with dec_potential=mem_rd_data and dec_rate=mem_rd_rate → WAIT.
- WAIT: hold until dec_done=1, then capture dec_result into the result register → WRITE.
- WRITE: mem_wr_en=1, with mem_wr_addr=addr and mem_wr_data=result.
  - If addr==NEURON_COUNT-1 → DONE.
  - Otherwise addr+1 → READ.
- DONE: sweep_done=1 → IDLE.
- busy=1 in every state except IDLE.
- timestep_start while busy:
  - set overrun;
  - the start is ignored and the current sweep continues.
- dec_done outside WAIT is ignored.
- Address counter never wraps mid-sweep. It is reset to 0 on entering READ from IDLE.
- No arithmetic on potentials; values pass through unmodified apart from decay.

## Timing
- Reset values: all outputs 0, state IDLE, addr 0, overrun 0.
- RESET mid-sweep:
  - returns to IDLE next cycle;
  - suppresses any write in that cycle;
  - the partial sweep is abandoned and not resumed.
- Start pulse at cycle t gives:
  - mem_rd_en at t+1;
  - dec_start at t+2;
  - with a 1-cycle decay unit, dec_done at t+3 and mem_wr_en at t+4.
- Per-neuron cost is 3 + D cycles, where D is the dec_start→dec_done latency.
- sweep_done comes one cycle after the last write. IDLE, and acc_grant availability, start the cycle after that.
- Strobes (mem_rd_en, dec_start, mem_wr_en, sweep_done) are single-cycle and registered.

## Configuration
- DECAY_SKIP_ZERO_EN defined:
  - In ISSUE, if mem_rd_data[30:0]==0 (±0.0), skip decay and writeback. Go directly to the next-address/DONE decision; dec_start and mem_wr_en stay 0.
  - Per-neuron cost for such neurons is 2 cycles.
- Undefined: every neuron is issued and written back regardless of value.

## Structure
- Shared package neuron_pkg holds:
  - float width (32) and rate-code width (5);
  - default ADDR_WIDTH;
  - the state enum encoding.
- One natural sub-module: neuron_address_counter (load-zero, increment, last-address flag).

## Test plan
- NEURON_COUNT=4, 1-cycle decay returning input/2:
  - one start pulse → four read/issue/write triples at addrs 0..3;
  - mem_wr_data 0x40800000 for stored 0x41000000;
  - sweep_done at t+17.
- Decay latency 5 cycles → dec_start→mem_wr_en spacing of 6 cycles; no second dec_start while in WAIT.
- timestep_start at t+6 of a sweep:
  - overrun=1 and stays 1;
  - the sweep completes normally with exactly NEURON_COUNT writes.
- RESET asserted during WAIT:
  - next cycle busy=0, no mem_wr_en;
  - a following start restarts at addr 0.
- acc_req held high across a sweep:
  - acc_grant=0 from the start cycle until the cycle after sweep_done, then 1;
  - acc_grant=0 in a cycle where acc_req and timestep_start coincide.
- DECAY_SKIP_ZERO_EN with stored values {0x00000000, 0x80000000, 0x3F800000, 0}:
  - only addr 2 sees dec_start/mem_wr_en;
  - sweep length is 11 cycles for D=1.
